memory_access_controller: RTL and testbench
===========================================

Name: memory_access_controller

Overview:
Sequences the MAR, the MDR and the synchronous RAM for a single load or store issued by the control unit. Accepts one read or write request at a time. Drives the MDR's memory/bus select and load enable, and the RAM read/write strobes, through a fixed number of wait states. Signals completion with a one-cycle done pulse. Sits between the control-unit FSM and the memory subsystem in the datapath.

Parameters:
ADDR_WIDTH, 9, width of the memory address latched from the bus.
WAIT_CYCLES, 1, RAM access wait states inserted between address phase and transfer (0..15).

Ports:
in_clk  input  1  system clock, rising-edge.
in_clr  input  1  asynchronous, active-low reset (0 = reset).
in_req_read  input  1  load request from the control unit, sampled in IDLE only.
in_req_write  input  1  store request from the control unit, sampled in IDLE only.
in_addr  input  ADDR_WIDTH  address from bus, sampled with the request.
out_mem_addr  output  ADDR_WIDTH  latched access address to RAM.
out_mar_write  output  1  MAR load enable.
out_mdr_read  output  1  MDR mux select: 1 = memory, 0 = bus.
out_mdr_write  output  1  MDR load enable.
out_mem_read  output  1  RAM read strobe.
out_mem_write  output  1  RAM write strobe.
out_busy  output  1  1 whenever state != IDLE.
out_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: in_clr=0 asynchronously forces IDLE. All outputs go to 0, out_mem_addr=0 and the wait counter goes to 0. Reset mid-access aborts with no further strobes; out_mem_write drops immediately.
- States: IDLE, ADDR, WAIT, XFER, DONE. One-hot or binary is an implementation choice; all outputs are Moore-decoded from registered state and op bit, so they are glitch-free.
- IDLE: on an edge with in_req_read or in_req_write=1:
  - latch in_addr into out_mem_addr and latch the op bit (read/write);
  - go to ADDR.
- Both requests high in IDLE: read wins; the write is dropped, not queued.
- ADDR: out_mar_write=1, and out_mem_read=1 if op=read. Next state is WAIT if WAIT_CYCLES>0, else XFER. The wait counter is loaded with WAIT_CYCLES-1.
- WAIT: out_mem_read=1 if op=read. The counter decrements each cycle; at 0 go to XFER. Exactly WAIT_CYCLES cycles are spent in WAIT.
- XFER:
  - read: out_mem_read=1, out_mdr_read=1, out_mdr_write=1 (MDR captures memory data at end of cycle);
  - write: out_mem_write=1 for exactly one cycle, out_mdr_read=0, out_mdr_write=0 (MDR holds store data).
- DONE: out_done=1 for one cycle, out_busy=1, then IDLE.
- Latency: request edge to out_done high = 3 + WAIT_CYCLES cycles. The next request can be accepted on the edge that leaves DONE+1, i.e. IDLE must be visited for at least one cycle.
- Requests asserted while busy are ignored; the control unit must hold a request until it sees out_done.
- out_mem_addr is stable from ADDR through DONE and holds its value in IDLE until the next accept.
- out_mem_read and out_mem_write are never high in the same cycle.

Optional Feature:
MEMCTL_PROTOCOL_CHECK_EN: adds output out_err (1 bit, reset 0), a sticky flag cleared only by in_clr. It is set on:
- both requests high in IDLE;
- any request high while in XFER or DONE, which is a control-unit protocol violation.
Read-priority behaviour is unchanged. Without the macro, the out_err port does not exist and no checking logic is built.

Test Plan:
- Reset with WAIT_CYCLES=1: hold in_clr=0 for 2 cycles -> all outputs 0, out_mem_addr=0, out_busy=0.
- Read: in_req_read=1, in_addr=9'h0A5 in IDLE -> ADDR asserts out_mar_write and out_mem_read; 1 WAIT cycle; XFER asserts out_mdr_read=1 and out_mdr_write=1; out_done 4 cycles after the accept edge; out_mem_addr=9'h0A5 throughout.
- Write with WAIT_CYCLES=0: in_req_write=1, in_addr=9'h1FF -> out_mem_write high for exactly 1 cycle, out_mdr_write=0 throughout, out_done 3 cycles after accept, out_mem_read never high.
- Simultaneous in_req_read=1 and in_req_write=1 at 9'h010 -> read sequence only, no out_mem_write. With MEMCTL_PROTOCOL_CHECK_EN, out_err=1 and stays 1.
- Reset mid-op: in_clr=0 during XFER of a write -> out_mem_write falls without waiting for a clock edge, state is IDLE, no out_done pulse.
- Back-to-back: hold in_req_read=1 continuously with WAIT_CYCLES=2 -> out_done pulses every 6 cycles, with one IDLE cycle between accesses.

Source files
------------

// File: rtl/memory_access_controller.sv
// Single-access MAR/MDR/RAM sequencer: IDLE -> ADDR -> WAIT x WAIT_CYCLES -> XFER -> DONE.
// Optional macro MEMCTL_PROTOCOL_CHECK_EN adds a sticky out_err protocol-violation flag.
module memory_access_controller #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  in_clk,
    input  logic                  in_clr,
    input  logic                  in_req_read,
    input  logic                  in_req_write,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic                  out_mar_write,
    output logic                  out_mdr_read,
    output logic                  out_mdr_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_busy,
`ifdef MEMCTL_PROTOCOL_CHECK_EN
    output logic                  out_err,
`endif
    output logic                  out_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state_q, state_d;
    logic                  op_rd_q, op_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            cnt_q, cnt_d;

    always_ff @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) begin
            state_q <= S_IDLE;
            op_rd_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op_rd_q <= op_rd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_rd_d = op_rd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Read has priority; a simultaneous write is dropped.
                if (in_req_read || in_req_write) begin
                    state_d = S_ADDR;
                    op_rd_d = in_req_read;
                    addr_d  = in_addr;
                end
            end
            S_ADDR: begin
                cnt_d   = CNT_INIT;
                state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_XFER;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_XFER;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_XFER:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded only from registered state and op bit.
    always_comb begin
        out_mar_write = 1'b0;
        out_mdr_read  = 1'b0;
        out_mdr_write = 1'b0;
        out_mem_read  = 1'b0;
        out_mem_write = 1'b0;
        out_done      = 1'b0;
        case (state_q)
            S_ADDR: begin
                out_mar_write = 1'b1;
                out_mem_read  = op_rd_q;
            end
            S_WAIT: out_mem_read = op_rd_q;
            S_XFER: begin
                out_mem_read  = op_rd_q;
                out_mdr_read  = op_rd_q;
                out_mdr_write = op_rd_q;
                out_mem_write = !op_rd_q;
            end
            S_DONE:  out_done = 1'b1;
            default: ;
        endcase
    end

    assign out_busy     = (state_q != S_IDLE);
    assign out_mem_addr = addr_q;

`ifdef MEMCTL_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && in_req_read && in_req_write)
            err_d = 1'b1;
        if ((state_q == S_XFER || state_q == S_DONE) && (in_req_read || in_req_write))
            err_d = 1'b1;
    end

    always_ff @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign out_err = err_q;
`endif

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench: three controllers (WAIT_CYCLES 0,1,2) share stimulus; an elapsed-cycle model predicts outputs.
module tb_memory_access_controller;
    localparam int AW = 9;
    localparam int N  = 3;
`ifdef MEMCTL_PROTOCOL_CHECK_EN
    localparam int VW = AW + 8;
`else
    localparam int VW = AW + 7;
`endif

    logic          in_clk = 1'b0;
    logic          in_clr = 1'b1;
    logic          rd = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;

    logic [N-1:0][AW-1:0] m_addr;
    logic [N-1:0] mar, mdr_rd, mdr_wr, mrd, mwr, busy, done;
`ifdef MEMCTL_PROTOCOL_CHECK_EN
    logic [N-1:0] err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 in_clk = ~in_clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        memory_access_controller #(.ADDR_WIDTH(AW), .WAIT_CYCLES(g)) u_dut (
            .in_clk       (in_clk),
            .in_clr       (in_clr),
            .in_req_read  (rd),
            .in_req_write (wr),
            .in_addr      (addr),
            .out_mem_addr (m_addr[g]),
            .out_mar_write(mar[g]),
            .out_mdr_read (mdr_rd[g]),
            .out_mdr_write(mdr_wr[g]),
            .out_mem_read (mrd[g]),
            .out_mem_write(mwr[g]),
            .out_busy     (busy[g]),
`ifdef MEMCTL_PROTOCOL_CHECK_EN
            .out_err      (err[g]),
`endif
            .out_done     (done[g])
        );
    end

    // Reference: ph = cycles elapsed since acceptance (-1 idle). An access with
    // W wait states spans ADDR(0), WAIT(1..W), XFER(W+1), DONE(W+2).
    int            ph[N];
    logic          mop[N];
    logic [AW-1:0] maddr[N];
    logic          merr[N];

    always @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) begin
            for (int d = 0; d < N; d++) begin
                ph[d] <= -1; mop[d] <= 1'b0; maddr[d] <= '0; merr[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < N; d++) begin
                if (ph[d] < 0) begin
                    if (rd && wr) merr[d] <= 1'b1;
                    if (rd || wr) begin
                        ph[d] <= 0; mop[d] <= rd; maddr[d] <= addr;
                    end
                end else begin
                    if (ph[d] > d && (rd || wr)) merr[d] <= 1'b1;
                    ph[d] <= (ph[d] == d + 2) ? -1 : ph[d] + 1;
                end
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec(input int d);
        int   p;
        logic r, xf, early;
        p = ph[d]; r = mop[d];
        xf = (p == d + 1);
        early = (p >= 0 && p <= d);
        return {maddr[d], p == 0, xf && r, xf && r, (early || xf) && r, xf && !r, p >= 0, p == d + 2
`ifdef MEMCTL_PROTOCOL_CHECK_EN
                , merr[d]
`endif
               };
    endfunction

    function automatic logic [VW-1:0] got_vec(input int d);
        return {m_addr[d], mar[d], mdr_rd[d], mdr_wr[d], mrd[d], mwr[d], busy[d], done[d]
`ifdef MEMCTL_PROTOCOL_CHECK_EN
                , err[d]
`endif
               };
    endfunction

    task automatic test_reset();
        @(negedge in_clk);
        in_clr = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0;
        repeat (2) begin
            @(negedge in_clk);
            for (int d = 0; d < N; d++) begin
                checks++;
                if (got_vec(d) !== '0) begin
                    errors++;
                    $display("FAIL reset w%0d: got %h expected 0", d, got_vec(d));
                end
            end
        end
        in_clr = 1'b1;
    endtask

    task automatic test_read();
        int done_at[N];
        for (int d = 0; d < N; d++) done_at[d] = -1;
        @(negedge in_clk);
        rd = 1'b1; addr = 9'h0A5;
        for (int c = 1; c <= 8; c++) begin
            @(negedge in_clk);
            rd = 1'b0;
            for (int d = 0; d < N; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL read w%0d c%0d: got %h expected %h", d, c, got_vec(d), exp_vec(d));
                end
                if (done[d] === 1'b1 && done_at[d] < 0) done_at[d] = c;
            end
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if (done_at[d] != 3 + d) begin
                errors++;
                $display("FAIL read_latency w%0d: got %0d expected %0d", d, done_at[d], 3 + d);
            end
        end
    endtask

    task automatic test_write();
        int done_at = -1, nwr = 0, nrd = 0, nmdr = 0;
        @(negedge in_clk);
        wr = 1'b1; addr = 9'h1FF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge in_clk);
            wr = 1'b0;
            for (int d = 0; d < N; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL write w%0d c%0d: got %h expected %h", d, c, got_vec(d), exp_vec(d));
                end
            end
            nwr += int'(mwr[0]); nrd += int'(mrd[0]); nmdr += int'(mdr_wr[0]);
            if (done[0] === 1'b1 && done_at < 0) done_at = c;
        end
        checks++;
        if (nwr != 1 || nrd != 0 || nmdr != 0 || done_at != 3) begin
            errors++;
            $display("FAIL write_w0: got wr=%0d rd=%0d mdr=%0d done@%0d expected 1 0 0 3", nwr, nrd, nmdr, done_at);
        end
    endtask

    task automatic test_both();
        int nwr = 0;
        @(negedge in_clk);
        rd = 1'b1; wr = 1'b1; addr = 9'h010;
        for (int c = 1; c <= 8; c++) begin
            @(negedge in_clk);
            rd = 1'b0; wr = 1'b0;
            for (int d = 0; d < N; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL both w%0d c%0d: got %h expected %h", d, c, got_vec(d), exp_vec(d));
                end
                nwr += int'(mwr[d]);
            end
        end
        checks++;
        if (nwr != 0) begin
            errors++;
            $display("FAIL both_nowrite: got %0d write strobes expected 0", nwr);
        end
`ifdef MEMCTL_PROTOCOL_CHECK_EN
        checks++;
        if (err !== '1) begin
            errors++;
            $display("FAIL both_err: got %b expected 111", err);
        end
`endif
    endtask

    task automatic test_reset_midop();
        @(negedge in_clk);
        wr = 1'b1; addr = 9'h15A;
        @(negedge in_clk);
        wr = 1'b0;
        @(posedge in_clk);
        #2;
        checks++;
        if (mwr[0] !== 1'b1) begin
            errors++;
            $display("FAIL midop_xfer: got mem_write=%b expected 1", mwr[0]);
        end
        in_clr = 1'b0;
        #1;
        for (int d = 0; d < N; d++) begin
            checks++;
            if (got_vec(d) !== '0) begin
                errors++;
                $display("FAIL midop_async w%0d: got %h expected 0", d, got_vec(d));
            end
        end
        @(negedge in_clk);
        in_clr = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge in_clk);
            for (int d = 0; d < N; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d) || done[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL midop_after w%0d c%0d: got %h expected %h", d, c, got_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int last[N], gaps[N];
        for (int d = 0; d < N; d++) begin last[d] = -1; gaps[d] = 0; end
        @(negedge in_clk);
        rd = 1'b1; addr = 9'($urandom);
        for (int c = 1; c <= 30; c++) begin
            @(negedge in_clk);
            for (int d = 0; d < N; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL b2b w%0d c%0d: got %h expected %h", d, c, got_vec(d), exp_vec(d));
                end
                if (done[d] === 1'b1) begin
                    if (last[d] >= 0) begin
                        gaps[d]++;
                        checks++;
                        if (c - last[d] != d + 4) begin
                            errors++;
                            $display("FAIL b2b_period w%0d: got %0d expected %0d", d, c - last[d], d + 4);
                        end
                    end
                    last[d] = c;
                end
            end
        end
        rd = 1'b0;
        checks++;
        if (gaps[2] < 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d periods expected at least 3", gaps[2]);
        end
        repeat (8) @(negedge in_clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge in_clk);
            for (int d = 0; d < N; d++) begin
                checks++;
                if (got_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL random w%0d c%0d: got %h expected %h", d, c, got_vec(d), exp_vec(d));
                end
            end
            rd     = ($urandom_range(3) == 0);
            wr     = ($urandom_range(3) == 0);
            addr   = 9'($urandom);
            in_clr = ($urandom_range(39) != 0);
        end
        in_clr = 1'b1; rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_both();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
